// File: rtl/mxv_seq_pkg.sv
// mxv_seq_pkg: shared state/error encodings and default delimiters for the MxV frame sequencer.
package mxv_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_END_CHK, S_ISSUE} seq_state_e;
    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_END     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } seq_err_e;
    localparam logic [7:0] DEF_START_BYTE = 8'hFE;
    localparam logic [7:0] DEF_END_BYTE   = 8'hEF;
endpackage

// File: rtl/mxv_frame_sequencer_if.sv
// mxv_frame_sequencer_if: UART byte input, payload output, command handshake and status of the sequencer.
interface mxv_frame_sequencer_if #(parameter int WORD_LENGTH = 8);
    logic                   rx_valid;
    logic [WORD_LENGTH-1:0] rx_data;
    logic                   cmd_ready;
    logic                   cmd_valid;
    logic [WORD_LENGTH-1:0] cmd_code;
    logic [WORD_LENGTH-1:0] cmd_length;
    logic                   payload_valid;
    logic [WORD_LENGTH-1:0] payload_data;
    logic [WORD_LENGTH-1:0] payload_index;
    logic                   frame_error;
    logic [1:0]             error_code;
    logic                   busy;
    modport master (
        input  rx_valid, rx_data, cmd_ready,
        output cmd_valid, cmd_code, cmd_length, payload_valid, payload_data, payload_index,
               frame_error, error_code, busy
    );
    modport slave (
        output rx_valid, rx_data, cmd_ready,
        input  cmd_valid, cmd_code, cmd_length, payload_valid, payload_data, payload_index,
               frame_error, error_code, busy
    );
endinterface

// File: rtl/mxv_frame_sequencer_frame_byte_counter.sv
// frame_byte_counter: payload position counter with sync clear, enable and last-byte flag.
module frame_byte_counter #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clear,
    input  logic [WIDTH-1:0] length,
    output logic [WIDTH-1:0] count,
    output logic             last
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (sync_clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    assign last = count == length - 1'b1;
endmodule

// File: rtl/mxv_frame_sequencer.sv
// mxv_frame_sequencer: parses START,CMD,LEN,payload,END frames into payload strobes and a handshaked command.
// Optional inter-byte timeout (error 11) is built only when SEQ_TIMEOUT_EN is defined.
module mxv_frame_sequencer import mxv_seq_pkg::*; #(
    parameter int                     WORD_LENGTH = 8,
    parameter logic [WORD_LENGTH-1:0] START_BYTE  = WORD_LENGTH'(DEF_START_BYTE),
    parameter logic [WORD_LENGTH-1:0] END_BYTE    = WORD_LENGTH'(DEF_END_BYTE),
    parameter int                     MAX_LEN     = 16
`ifdef SEQ_TIMEOUT_EN
    , parameter int                   TIMEOUT_CYCLES = 1000
`endif
) (
    input logic                   clk,
    input logic                   reset,
    mxv_frame_sequencer_if.master bus
);
    typedef logic [WORD_LENGTH-1:0] word_t;
    seq_state_e state, state_n;
    seq_err_e   err, err_n;
    logic  cmd_valid, cmd_valid_n, payload_valid, payload_valid_n, frame_error, frame_error_n;
    word_t cmd_code, cmd_code_n, cmd_length, cmd_length_n;
    word_t payload_data, payload_data_n, payload_index, payload_index_n, count;
    logic  cnt_en, cnt_clr, last, timeout;

    frame_byte_counter #(.WIDTH(WORD_LENGTH)) u_cnt (
        .clk(clk), .reset(reset), .enable(cnt_en), .sync_clear(cnt_clr),
        .length(cmd_length), .count(count), .last(last)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic          counting;
    assign counting = state inside {S_CMD, S_LEN, S_PAYLOAD, S_END_CHK};
    // A byte arriving on the expiry cycle suppresses the timeout.
    assign timeout  = counting && !bus.rx_valid && timer == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) timer <= '0;
        else if (bus.rx_valid || timeout) timer <= '0;
        else if (counting) timer <= timer + 1'b1;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= S_IDLE;
            err           <= ERR_NONE;
            cmd_valid     <= 1'b0;
            cmd_code      <= '0;
            cmd_length    <= '0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            payload_index <= '0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_n;
            err           <= err_n;
            cmd_valid     <= cmd_valid_n;
            cmd_code      <= cmd_code_n;
            cmd_length    <= cmd_length_n;
            payload_valid <= payload_valid_n;
            payload_data  <= payload_data_n;
            payload_index <= payload_index_n;
            frame_error   <= frame_error_n;
        end

    always_comb begin
        state_n         = state;
        err_n           = err;
        cmd_valid_n     = cmd_valid;
        cmd_code_n      = cmd_code;
        cmd_length_n    = cmd_length;
        payload_valid_n = 1'b0;
        payload_data_n  = payload_data;
        payload_index_n = payload_index;
        frame_error_n   = 1'b0;
        cnt_en          = 1'b0;
        cnt_clr         = 1'b0;
        if (timeout) begin
            state_n       = S_IDLE;
            err_n         = ERR_TIMEOUT;
            frame_error_n = 1'b1;
        end else case (state)
            S_IDLE: state_n = bus.rx_valid && bus.rx_data == START_BYTE ? S_CMD : S_IDLE;
            S_CMD: if (bus.rx_valid) begin
                cmd_code_n = bus.rx_data;
                state_n    = S_LEN;
            end
            S_LEN: if (bus.rx_valid) begin
                if (bus.rx_data == '0 || bus.rx_data > word_t'(MAX_LEN)) begin
                    err_n         = ERR_LEN;
                    frame_error_n = 1'b1;
                    state_n       = S_IDLE;
                end else begin
                    cmd_length_n = bus.rx_data;
                    cnt_clr      = 1'b1;
                    state_n      = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (bus.rx_valid) begin
                payload_valid_n = 1'b1;
                payload_data_n  = bus.rx_data;
                payload_index_n = count;
                cnt_en          = !last;
                cnt_clr         = last;
                state_n         = last ? S_END_CHK : S_PAYLOAD;
            end
            S_END_CHK: if (bus.rx_valid) begin
                if (bus.rx_data == END_BYTE) begin
                    cmd_valid_n = 1'b1;
                    state_n     = S_ISSUE;
                end else begin
                    err_n         = ERR_END;
                    frame_error_n = 1'b1;
                    state_n       = S_IDLE;
                end
            end
            S_ISSUE: if (cmd_valid && bus.cmd_ready) begin
                cmd_valid_n = 1'b0;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.cmd_valid     = cmd_valid;
    assign bus.cmd_code      = cmd_code;
    assign bus.cmd_length    = cmd_length;
    assign bus.payload_valid = payload_valid;
    assign bus.payload_data  = payload_data;
    assign bus.payload_index = payload_index;
    assign bus.frame_error   = frame_error;
    assign bus.error_code    = err;
    assign bus.busy          = state != S_IDLE;
endmodule
